ob_cn_issue_arb: RTL and testbench

OB_CN_ISSUE_ARB -- requirements
Module: ob_cn_issue_arb

---
 rtl/ob_pkg.sv | 22 ++
 rtl/ob_cn_rr_arb.sv | 32 +++
 rtl/ob_cn_issue_arb.sv | 90 +++++++++
 tb/tb_ob_cn_issue_arb.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/ob_pkg.sv
// Shared order-book types: command opcodes, uid and the packed command record.
// OB_CN_N sets the entry count of the conditional table that feeds the issue arbiter.
package ob_pkg;

   typedef enum logic [1:0] {
      OP_NOP,
      OP_BUY,
      OP_SELL,
      OP_CXL
   } opcode_t;

   typedef logic [7:0] uid_t;

   typedef struct packed {
      opcode_t     op;
      uid_t        uid;
      logic [15:0] qty;
   } cmd_t;

   localparam int unsigned OB_CN_N = 4;

endpackage

// File: rtl/ob_cn_rr_arb.sv
// Round-robin one-hot picker: first set cand bit at or above ptr, wrapping N-1 -> 0.
module ob_cn_rr_arb #(
   parameter int N = 4
) (
   input  logic [N-1:0]         cand,
   input  logic [$clog2(N)-1:0] ptr,
   output logic [N-1:0]         grant,
   output logic [$clog2(N)-1:0] gidx,
   output logic                 any
);

   localparam int          PW = $clog2(N);
   localparam int unsigned NU = N;

   logic [PW-1:0] idx;

   always_comb begin
      grant = '0;
      gidx  = '0;
      any   = 1'b0;
      idx   = '0;
      for (int unsigned off = 0; off < NU; off++) begin
         idx = PW'((32'(ptr) + off) % NU);
         if (!any && cand[idx]) begin
            grant[idx] = 1'b1;
            gidx       = idx;
            any        = 1'b1;
         end
      end
   end

endmodule

// File: rtl/ob_cn_issue_arb.sv
// Issue arbiter: picks one matured conditional entry round-robin into a single-deep
// issue register that refills back-to-back on accept or on a cancel of the held command.
module ob_cn_issue_arb
   import ob_pkg::*;
#(
   parameter int N = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N-1:0]         mtr_vld,
   input  cmd_t [N-1:0]         mtr_cmd,
   output logic [N-1:0]         dl_vld,
   output logic                 iss_vld,
   output cmd_t                 iss_cmd,
   input  logic                 iss_accept,
   input  logic                 cancel,
   input  uid_t                 cancel_uid,
   output logic                 cancel_hit,
   output logic                 busy_r
);

   localparam int PW = $clog2(N);

   typedef enum logic {
      ST_EMPTY,
      ST_FULL
   } state_t;

   state_t        state_r, state_nx;
   cmd_t          cmd_r, cmd_nx;
   logic [PW-1:0] ptr_r, ptr_nx;

   logic [N-1:0]  cand;
   logic [N-1:0]  grant;
   logic [PW-1:0] gidx;
   logic          any;
   logic          grant_en;

   // An entry whose own uid is being cancelled this cycle must not be picked.
   always_comb begin
      cand = '0;
      for (int unsigned i = 0; i < N; i++) begin
         cand[i] = mtr_vld[i] & ~(cancel & (mtr_cmd[i].uid == cancel_uid));
      end
   end

   ob_cn_rr_arb #(.N(N)) u_rr (
      .cand  (cand),
      .ptr   (ptr_r),
      .grant (grant),
      .gidx  (gidx),
      .any   (any)
   );

   always_comb begin
      cancel_hit = rst & cancel & (state_r == ST_FULL) &
                   (cmd_r.uid == cancel_uid) & ~iss_accept;
      grant_en   = rst & any &
                   ((state_r == ST_EMPTY) | iss_accept | cancel_hit);
      dl_vld     = grant_en ? grant : '0;

      state_nx = state_r;
      cmd_nx   = cmd_r;
      ptr_nx   = ptr_r;
      if (grant_en) begin
         state_nx = ST_FULL;
         cmd_nx   = mtr_cmd[gidx];
         ptr_nx   = (gidx == PW'(N - 1)) ? '0 : gidx + 1'b1;
      end else if ((state_r == ST_FULL) && (iss_accept || cancel_hit)) begin
         state_nx = ST_EMPTY;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r <= ST_EMPTY;
         cmd_r   <= '0;
         ptr_r   <= '0;
      end else begin
         state_r <= state_nx;
         cmd_r   <= cmd_nx;
         ptr_r   <= ptr_nx;
      end
   end

   assign iss_vld = (state_r == ST_FULL);
   assign busy_r  = (state_r == ST_FULL);
   assign iss_cmd = cmd_r;

endmodule

// File: tb/tb_ob_cn_issue_arb.sv
// Directed bench for ob_cn_issue_arb: reset, single mature, fairness, backpressure,
// held and candidate cancel, and reset mid-operation.
module tb_ob_cn_issue_arb;
   import ob_pkg::*;

   localparam int N = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic [N-1:0] mtr_vld;
   cmd_t [N-1:0] mtr_cmd;
   logic [N-1:0] dl_vld;
   logic         iss_vld;
   cmd_t         iss_cmd;
   logic         iss_accept;
   logic         cancel;
   uid_t         cancel_uid;
   logic         cancel_hit;
   logic         busy_r;

   int checks   = 0;
   int failures = 0;

   ob_cn_issue_arb #(.N(N)) dut (
      .clk        (clk),
      .rst        (rst),
      .mtr_vld    (mtr_vld),
      .mtr_cmd    (mtr_cmd),
      .dl_vld     (dl_vld),
      .iss_vld    (iss_vld),
      .iss_cmd    (iss_cmd),
      .iss_accept (iss_accept),
      .cancel     (cancel),
      .cancel_uid (cancel_uid),
      .cancel_hit (cancel_hit),
      .busy_r     (busy_r)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic cmd_t mk(input uid_t u);
      cmd_t c;
      c.op  = OP_BUY;
      c.uid = u;
      c.qty = 16'(100 + int'(u));
      return c;
   endfunction

   function automatic logic [31:0] cw(input cmd_t c);
      return {6'd0, c};
   endfunction

   task automatic to_neg();
      @(negedge clk);
   endtask

   task automatic to_pos();
      @(posedge clk);
      #1;
   endtask

   int ord [5] = '{0, 1, 2, 3, 0};
   int prev;

   initial begin
      for (int i = 0; i < N; i++) mtr_cmd[i] = mk(8'(16 + i));

      // reset with busy inputs
      rst = 1'b0; mtr_vld = 4'b1111; iss_accept = 1'b1; cancel = 1'b1; cancel_uid = 8'h10;
      for (int k = 0; k < 2; k++) begin
         to_neg();
         check("rst_dl", 32'(dl_vld), 32'h0);
         check("rst_hit", 32'(cancel_hit), 32'h0);
         to_pos();
      end
      check("rst_iss_vld", 32'(iss_vld), 32'h0);
      check("rst_busy", 32'(busy_r), 32'h0);
      check("rst_cmd", cw(iss_cmd), 32'h0);
      check("rst_ptr", 32'(dut.ptr_r), 32'h0);

      rst = 1'b1; mtr_vld = '0; iss_accept = 1'b0; cancel = 1'b0;
      to_neg();
      check("idle_dl", 32'(dl_vld), 32'h0);
      to_pos();

      // single mature
      mtr_vld = 4'b0100;
      to_neg();
      check("single_dl", 32'(dl_vld), 32'b0100);
      check("single_pre_vld", 32'(iss_vld), 32'h0);
      to_pos();
      mtr_vld = '0;
      check("single_iss_vld", 32'(iss_vld), 32'h1);
      check("single_busy", 32'(busy_r), 32'h1);
      check("single_cmd", cw(iss_cmd), cw(mk(8'h12)));
      check("single_ptr", 32'(dut.ptr_r), 32'd3);
      to_neg();
      check("single_dl_clr", 32'(dl_vld), 32'h0);

      iss_accept = 1'b1;
      to_pos();
      check("drain1_vld", 32'(iss_vld), 32'h0);
      iss_accept = 1'b0;

      // set ptr to 0 by granting entry 3
      mtr_vld = 4'b1000;
      to_neg();
      check("pre_fair_dl", 32'(dl_vld), 32'b1000);
      to_pos();
      check("pre_fair_ptr", 32'(dut.ptr_r), 32'd0);

      // fairness
      mtr_vld = 4'b1111; iss_accept = 1'b1; prev = 3;
      for (int k = 0; k < 5; k++) begin
         to_neg();
         check($sformatf("fair_dl%0d", k), 32'(dl_vld), 32'(1 << ord[k]));
         check($sformatf("fair_cmd%0d", k), cw(iss_cmd), cw(mk(8'(16 + prev))));
         to_pos();
         prev = ord[k];
      end
      mtr_vld = '0;
      to_neg();
      check("fair_tail_dl", 32'(dl_vld), 32'h0);
      check("fair_tail_cmd", cw(iss_cmd), cw(mk(8'h10)));
      to_pos();
      check("fair_tail_vld", 32'(iss_vld), 32'h0);
      check("fair_ptr", 32'(dut.ptr_r), 32'd1);
      iss_accept = 1'b0;

      // backpressure: hold entry 0, entry 1 waits
      mtr_vld = 4'b0001;
      to_neg();
      check("bp_wrap_dl", 32'(dl_vld), 32'b0001);
      to_pos();
      mtr_vld = 4'b0010;
      for (int k = 0; k < 5; k++) begin
         to_neg();
         check($sformatf("bp_dl%0d", k), 32'(dl_vld), 32'h0);
         check($sformatf("bp_cmd%0d", k), cw(iss_cmd), cw(mk(8'h10)));
         check($sformatf("bp_vld%0d", k), 32'(iss_vld), 32'h1);
         to_pos();
      end
      iss_accept = 1'b1;
      to_neg();
      check("bp_acc_dl", 32'(dl_vld), 32'b0010);
      to_pos();
      iss_accept = 1'b0; mtr_vld = '0;
      check("bp_refill_cmd", cw(iss_cmd), cw(mk(8'h11)));
      check("bp_ptr", 32'(dut.ptr_r), 32'd2);

      // held cancel
      mtr_cmd[2] = mk(8'd7);
      iss_accept = 1'b1;
      to_pos();
      iss_accept = 1'b0;
      check("hc_drain_vld", 32'(iss_vld), 32'h0);
      mtr_vld = 4'b0100;
      to_pos();
      mtr_vld = '0;
      check("hc_cmd", cw(iss_cmd), cw(mk(8'd7)));
      cancel = 1'b1; cancel_uid = 8'd8;
      to_neg();
      check("hc_miss_hit", 32'(cancel_hit), 32'h0);
      to_pos();
      check("hc_miss_vld", 32'(iss_vld), 32'h1);
      cancel_uid = 8'd7;
      to_neg();
      check("hc_hit", 32'(cancel_hit), 32'h1);
      check("hc_dl", 32'(dl_vld), 32'h0);
      to_pos();
      check("hc_empty", 32'(iss_vld), 32'h0);
      cancel = 1'b0;

      mtr_vld = 4'b0100;
      to_pos();
      mtr_vld = '0;
      check("hc2_ptr", 32'(dut.ptr_r), 32'd3);
      cancel = 1'b1; cancel_uid = 8'd7; iss_accept = 1'b1;
      to_neg();
      check("hc2_hit", 32'(cancel_hit), 32'h0);
      check("hc2_vld", 32'(iss_vld), 32'h1);
      check("hc2_cmd", cw(iss_cmd), cw(mk(8'd7)));
      to_pos();
      check("hc2_issued", 32'(iss_vld), 32'h0);
      cancel = 1'b0; iss_accept = 1'b0;

      // candidate cancel
      mtr_cmd[0] = mk(8'd9);
      mtr_vld = 4'b0001; cancel = 1'b1; cancel_uid = 8'd9;
      to_neg();
      check("cc_dl", 32'(dl_vld), 32'h0);
      to_pos();
      check("cc_vld", 32'(iss_vld), 32'h0);
      cancel = 1'b0;
      to_neg();
      check("cc_release_dl", 32'(dl_vld), 32'b0001);
      to_pos();
      mtr_vld = '0;
      check("cc_vld2", 32'(iss_vld), 32'h1);
      check("cc_cmd", cw(iss_cmd), cw(mk(8'd9)));
      check("cc_ptr", 32'(dut.ptr_r), 32'd1);

      // reset while FULL
      rst = 1'b0; mtr_vld = 4'b1111; iss_accept = 1'b1; cancel = 1'b1; cancel_uid = 8'd9;
      to_neg();
      check("mrst_dl", 32'(dl_vld), 32'h0);
      check("mrst_hit", 32'(cancel_hit), 32'h0);
      to_pos();
      check("mrst_vld", 32'(iss_vld), 32'h0);
      check("mrst_busy", 32'(busy_r), 32'h0);
      check("mrst_ptr", 32'(dut.ptr_r), 32'd0);
      check("mrst_cmd", cw(iss_cmd), 32'h0);
      rst = 1'b1; mtr_vld = '0; cancel = 1'b0; iss_accept = 1'b0;
      to_neg();
      check("post_rst_vld", 32'(iss_vld), 32'h0);
      to_pos();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
